// File: rtl/rx.sv
// UART 8N1 receiver: 2-flop synchronized line, mid-bit sampling, one-cycle valid/ferr strobes.
// Define RX_MAJORITY_EN to take every sample as a 2-of-3 vote around the nominal sample point.
module rx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxline,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);
    // state  | meaning
    // S_IDLE | line idle, waiting for a falling edge
    // S_START| timing to mid start bit, rejecting glitches
    // S_DATA | sampling 8 data bits, LSB first
    // S_STOP | sampling the stop bit
    // S_BRK  | stop bit was low; wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
`ifdef RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so the start decision slips one cycle;
    // later sample points keep full-bit spacing from it.
    localparam logic [CW-1:0] CNT_START = CW'(BAUD_DIV / 2);
`else
    localparam logic [CW-1:0] CNT_START = CW'(BAUD_DIV / 2 - 1);
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bitn, bitn_n;
    logic [7:0]      sh, sh_n;
    logic [7:0]      data_n;
    logic            valid_n, ferr_n;
    logic            sync1, rxs;
    logic            samp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxline;
            rxs   <= sync1;
        end
    end

`ifdef RX_MAJORITY_EN
    logic hist1, hist2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1 <= 1'b1;
            hist2 <= 1'b1;
        end else begin
            hist1 <= rxs;
            hist2 <= hist1;
        end
    end

    assign samp = (hist1 & hist2) | (hist1 & rxs) | (hist2 & rxs);
`else
    assign samp = rxs;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= 3'd0;
            sh    <= 8'h00;
            data  <= 8'h00;
            valid <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            sh    <= sh_n;
            data  <= data_n;
            valid <= valid_n;
            ferr  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bitn_n  = bitn;
        sh_n    = sh;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_START) begin
                    cnt_n = '0;
                    if (!samp) begin
                        state_n = S_DATA;
                        bitn_n  = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n  = '0;
                    sh_n   = {samp, sh[7:1]};
                    bitn_n = bitn + 3'd1;
                    if (bitn == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n = '0;
                    if (samp) begin
                        data_n  = sh;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BRK;
                    end
                end
            end
            S_BRK: begin
                cnt_n = '0;
                if (rxs) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rx.sv
// Scoreboard bench for rx: each driven frame pushes its expected byte and strobe time,
// and the output monitor pops and compares when valid or ferr fires.
module tb_rx;
    localparam int BAUD_DIV = 16;
`ifdef RX_MAJORITY_EN
    localparam int LAT = 3 + BAUD_DIV / 2 + 9 * BAUD_DIV;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int LAT = 2 + BAUD_DIV / 2 + 9 * BAUD_DIV;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxline = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, busy;

    rx #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxline(rxline),
        .data  (data),
        .valid (valid),
        .ferr  (ferr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t       vq[$];
    exp_t       fq[$];
    exp_t       ev;
    logic [7:0] model_data = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         gap, n, t0g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: any strobe without a queued expectation is a failure.
    always @(negedge clk) begin
        if (rst) begin
            if (valid && ferr) chk("valid_ferr_excl", 1, 0);
            if (valid) begin
                if (vq.size() == 0) chk("unexp_valid", 1, 0);
                else begin
                    ev = vq.pop_front();
                    chk("data", data, ev.d);
                    chk("valid_time", cyc, ev.at);
                    model_data = ev.d;
                end
            end
            if (ferr) begin
                if (fq.size() == 0) chk("unexp_ferr", 1, 0);
                else begin
                    ev = fq.pop_front();
                    chk("ferr_time", cyc, ev.at);
                    chk("ferr_data_held", data, model_data);
                end
            end
        end
    end

    // Drives one 10-bit frame; iteration i sets the level captured by the first sync flop at edge t0+i.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch,
                              input int abort_at, input logic [7:0] exp_d);
        exp_t x;
        int   idx;
        logic v;
        for (int i = 0; i < 10 * BAUD_DIV; i++) begin
            if (i == abort_at) return;
            @(negedge clk);
            if (i == 0 && abort_at < 0) begin
                x.d  = exp_d;
                x.at = cyc + 1 + LAT;
                if (stop) vq.push_back(x);
                else fq.push_back(x);
            end
            idx = i / BAUD_DIV;
            if (idx == 0) v = 1'b0;
            else if (idx == 9) v = stop;
            else v = b[idx-1];
            if (i == glitch) v = ~v;
            rxline = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h77, 1'b1, -1, -1, 8'h77);
        repeat (20) @(negedge clk);

        // back-to-back frames with busy-gap measurement
        gap = 0;
        n = 0;
        fork
            begin
                send_frame(8'h61, 1'b1, -1, -1, 8'h61);
                send_frame(8'h62, 1'b1, -1, -1, 8'h62);
            end
            begin
                while (!valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_first_valid_seen", valid, 1);
                n = 0;
                while (!busy && n < 50) begin
                    gap++;
                    @(negedge clk);
                    n++;
                end
                chk("b2b_gap_le8", (gap > 0 && gap <= 8), 1);
            end
        join
        repeat (20) @(negedge clk);
        chk("b2b_last_data", data, 8'h62);

        // short low pulse must be rejected
        @(negedge clk);
        t0g = cyc + 1;
        rxline = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rxline = 1'b1;
        while (cyc < t0g + 11) @(negedge clk);
        chk("glitch_busy", busy, 0);
        repeat (30) @(negedge clk);
        chk("glitch_data", data, 8'h62);

        // framing error followed by a held-low break
        send_frame(8'h00, 1'b0, -1, -1, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 0) begin
                chk("break_data_held", data, 8'h62);
                chk("break_busy", busy, 1);
            end
        end
        rxline = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h65, 1'b1, -1, -1, 8'h65);
        repeat (20) @(negedge clk);

        // reset in the middle of data bit 4
        send_frame(8'hC3, 1'b1, -1, 5 * BAUD_DIV + BAUD_DIV / 2, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        rxline = 1'b1;
        @(negedge clk);
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", valid, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_data = 8'h00;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1, -1, 8'h5A);
        repeat (20) @(negedge clk);

        // one-cycle high glitch on the bit-3 sample point of a 0x00 frame
        send_frame(8'h00, 1'b1, 3 * BAUD_DIV + BAUD_DIV + BAUD_DIV / 2, -1, GLITCH_EXP);
        repeat (20) @(negedge clk);

        n = 0;
        while ((vq.size() != 0 || fq.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("valid_queue_drained", vq.size(), 0);
        chk("ferr_queue_drained", fq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
